dvi_video_timing: RTL and testbench
===================================

DVI_VIDEO_TIMING -- requirements
Module: dvi_video_timing

Interface
REQ-001 Parameter H_ACTIVE, 640, active pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, 96, hsync width in clocks.
REQ-004 Parameter H_BP, 48, horizontal back porch in clocks.
REQ-005 Parameter V_ACTIVE, 480, active lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vsync width in lines.
REQ-008 Parameter V_BP, 33, vertical back porch in lines.
REQ-009 Parameter HS_POL, 0, hsync active level (0 = active low, 1 = active high).
REQ-010 Parameter VS_POL, 0, vsync active level (0 = active low, 1 = active high).
REQ-011 CLK  in  1  pixel clock; the only clock; same clock as the downstream DVI transmitter CLK.
REQ-012 RESET  in  1  synchronous, active-high reset.
REQ-013 ENABLE  in  1  run request; sampled at frame boundaries only.
REQ-014 PAT_SEL  in  2  source: 0 = external pixel, 1 = colour bars, 2 = grid, 3 = solid grey.
REQ-015 PIX_RED / PIX_GRN / PIX_BLU  in  8 each  external pixel, valid exactly 2 clocks after its PIX_REQ.
REQ-016 PIX_REQ  out  1  external pixel fetch strobe.
REQ-017 PIX_X  out  12  column of the requested pixel; PIX_Y  out  12  row of the requested pixel.
REQ-018 TX_RED / TX_GRN / TX_BLU  out  8 each; TX_HS, TX_VS, TX_DE  out  1 each; drive the DVI transmitter inputs.
REQ-019 FRAME_START  out  1  one-clock pulse; LINE_START  out  1  one-clock pulse.

Function
REQ-020 Counters: h_cnt runs 0..H_TOTAL-1, H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; v_cnt runs 0..V_TOTAL-1 and increments when h_cnt wraps.
REQ-021 Region order per axis: active [0,ACTIVE), front porch, sync, back porch; v_cnt wraps to 0 after V_TOTAL-1.
REQ-022 Stage 0 (counters): PIX_REQ = (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE && running); PIX_X = h_cnt and PIX_Y = v_cnt whenever PIX_REQ = 1, otherwise 0.
REQ-023 HS is active when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
REQ-024 VS is active when v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); VS changes only in clocks where h_cnt = 0.
REQ-025 Pipeline: TX_* outputs are registered copies of the stage-0 decode delayed exactly 2 clocks, so TX_DE rises 2 clocks after PIX_REQ rises.
REQ-026 TX_RGB source when TX_DE = 1, by PAT_SEL:
  - 0: PIX_* sampled in that clock.
  - 1: 8 equal-width bars (bar = x*8/H_ACTIVE) in order white, yellow, cyan, green, magenta, red, blue, black; components 0xFF/0x00.
  - 2: grid; 0xFFFFFF when x[3:0]==0 or y[3:0]==0, else 0x000000.
  - 3: 0x808080.
REQ-027 TX_RGB = 0 whenever TX_DE = 0.
REQ-028 PAT_SEL is captured at stage 0 and pipelined with the pixel; a change of PAT_SEL takes effect per pixel with no glitch or mixing.
REQ-029 FRAME_START pulses with the TX_* outputs of h=0, v=0; LINE_START pulses with the TX_* outputs of h=0 for every line, including blanking lines.
REQ-030 State machine IDLE/RUN.
  - IDLE: counters held at 0, PIX_REQ = 0, TX_DE = 0, HS/VS inactive.
  - IDLE -> RUN when ENABLE = 1; h=0, v=0 is issued in the next clock.
  - RUN -> IDLE only at the frame wrap (h=H_TOTAL-1, v=V_TOTAL-1) with ENABLE = 0.
  - Deasserting ENABLE mid-frame completes the current frame.
REQ-031 ENABLE = 1 at a frame wrap continues with no gap clock.
REQ-032 Counter widths are 12 bits; parameters giving H_TOTAL or V_TOTAL > 4096 are unsupported.

Reset
REQ-033 RESET = 1 at a CLK edge forces IDLE, h_cnt = v_cnt = 0, and clears the pipeline.
REQ-034 Reset output values: PIX_REQ = 0, PIX_X = PIX_Y = 0, TX_RGB = 0, TX_DE = 0, FRAME_START = LINE_START = 0, TX_HS = ~HS_POL, TX_VS = ~VS_POL.
REQ-035 Reset mid-frame takes effect in the next clock; no partial line is emitted afterwards.

Verification
Parameters for all scenarios: H 8/2/2/2 (total 14), V 4/1/1/1 (total 7), POL 0.
REQ-036 Release reset with ENABLE=1, PAT_SEL=0 -> PIX_REQ high for clocks 1..8 with PIX_X 0..7; TX_DE high 2 clocks later; TX_HS low for h=10,11; FRAME_START pulse coincides with the first TX_DE.
REQ-037 Drive PIX_* = {x,y,x^y} from a 2-cycle registered model -> TX_RGB equals the model value for every active pixel; 32 pixels per frame; 98 clocks per frame.
REQ-038 PAT_SEL=1 -> TX_RGB sequence per line = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
REQ-039 Drop ENABLE at v=1 -> frame completes; VS low during v=5 only; then IDLE holds TX_HS=TX_VS=1 and TX_DE=0; raise ENABLE -> FRAME_START follows 3 clocks later.
REQ-040 Assert RESET for 1 clock at h=3, v=2 -> next clock all outputs equal the REQ-034 values; the run restarts from h=0, v=0.
REQ-041 PAT_SEL=2 -> TX_RGB = FFFFFF for all of line 0 and for column 0 of every line, 000000 elsewhere in the active area.

Source files
------------

// File: rtl/dvi_video_timing.sv
// Raster timing generator for a DVI transmitter: frame/line counters, sync decode,
// a two-stage aligned pipeline and built-in test patterns, all on the pixel clock.
module dvi_video_timing #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        ENABLE,
   input  logic [1:0]  PAT_SEL,
   input  logic [7:0]  PIX_RED,
   input  logic [7:0]  PIX_GRN,
   input  logic [7:0]  PIX_BLU,
   output logic        PIX_REQ,
   output logic [11:0] PIX_X,
   output logic [11:0] PIX_Y,
   output logic [7:0]  TX_RED,
   output logic [7:0]  TX_GRN,
   output logic [7:0]  TX_BLU,
   output logic        TX_HS,
   output logic        TX_VS,
   output logic        TX_DE,
   output logic        FRAME_START,
   output logic        LINE_START
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
   localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam int PIPE_DEPTH = 2;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   // Everything a pixel needs to reach the transmitter in step with its position.
   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic        fs;
      logic        ls;
      logic [1:0]  pat;
      logic [11:0] x;
      logic [3:0]  y_lo;
   } pipe_t;

   state_t      state_reg, state_next;
   logic [11:0] h_cnt_reg, h_cnt_next;
   logic [11:0] v_cnt_reg, v_cnt_next;
   logic        run_next;
   logic        active_next;
   pipe_t       stage_next;
   pipe_t       pipe_reg [PIPE_DEPTH];
   pipe_t       pipe_last;
   logic        pix_req_reg;
   logic [11:0] pix_x_reg;
   logic [11:0] pix_y_reg;

   logic [2:0]       bar;
   logic [2:0][7:0]  pat_rgb;
   logic [2:0][7:0]  pix_rgb;
   logic [2:0][7:0]  tx_rgb;
   logic [2:0][7:0]  tx_rgb_reg;
   logic [1:0]       tx_pat_reg;
   logic             tx_de_reg;
   logic             tx_hs_reg;
   logic             tx_vs_reg;
   logic             tx_fs_reg;
   logic             tx_ls_reg;

   // ENABLE is only consulted when idle or at the last clock of a frame.
   always_comb begin
      state_next = state_reg;
      h_cnt_next = h_cnt_reg;
      v_cnt_next = v_cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            h_cnt_next = '0;
            v_cnt_next = '0;
            if (ENABLE) state_next = ST_RUN;
         end
         default: begin
            if (h_cnt_reg == H_LAST) begin
               h_cnt_next = '0;
               if (v_cnt_reg == V_LAST) begin
                  v_cnt_next = '0;
                  if (!ENABLE) state_next = ST_IDLE;
               end else begin
                  v_cnt_next = v_cnt_reg + 12'd1;
               end
            end else begin
               h_cnt_next = h_cnt_reg + 12'd1;
            end
         end
      endcase
   end

   always_comb begin
      run_next    = (state_next == ST_RUN);
      active_next = run_next && (h_cnt_next < H_ACT) && (v_cnt_next < V_ACT);
      stage_next.de   = active_next;
      stage_next.hs   = run_next && (h_cnt_next >= HS_BEG) && (h_cnt_next < HS_END);
      stage_next.vs   = run_next && (v_cnt_next >= VS_BEG) && (v_cnt_next < VS_END);
      stage_next.fs   = run_next && (h_cnt_next == 12'd0) && (v_cnt_next == 12'd0);
      stage_next.ls   = run_next && (h_cnt_next == 12'd0);
      stage_next.pat  = PAT_SEL;
      stage_next.x    = active_next ? h_cnt_next : 12'd0;
      stage_next.y_lo = active_next ? v_cnt_next[3:0] : 4'd0;
   end

   assign pipe_last = pipe_reg[PIPE_DEPTH-1];

   // Pattern colour for the pixel leaving the last stage; channel index 0/1/2 = R/G/B.
   always_comb begin
      bar     = 3'((int'(pipe_last.x) * 8) / H_ACTIVE);
      pat_rgb = '0;
      case (pipe_last.pat)
         2'd1: pat_rgb = {{8{~bar[0]}}, {8{~bar[2]}}, {8{~bar[1]}}};
         2'd2: begin
            if ((pipe_last.x[3:0] == 4'd0) || (pipe_last.y_lo == 4'd0))
               pat_rgb = {3{8'hFF}};
         end
         2'd3: pat_rgb = {3{8'h80}};
         default: pat_rgb = '0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg   <= ST_IDLE;
         h_cnt_reg   <= '0;
         v_cnt_reg   <= '0;
         pix_req_reg <= 1'b0;
         pix_x_reg   <= '0;
         pix_y_reg   <= '0;
         for (int i = 0; i < PIPE_DEPTH; i++) pipe_reg[i] <= '0;
         tx_de_reg   <= 1'b0;
         tx_hs_reg   <= ~HS_POL;
         tx_vs_reg   <= ~VS_POL;
         tx_fs_reg   <= 1'b0;
         tx_ls_reg   <= 1'b0;
         tx_pat_reg  <= 2'd0;
         tx_rgb_reg  <= '0;
      end else begin
         state_reg   <= state_next;
         h_cnt_reg   <= h_cnt_next;
         v_cnt_reg   <= v_cnt_next;
         pix_req_reg <= active_next;
         pix_x_reg   <= active_next ? h_cnt_next : 12'd0;
         pix_y_reg   <= active_next ? v_cnt_next : 12'd0;
         pipe_reg[0] <= stage_next;
         for (int i = 1; i < PIPE_DEPTH; i++) pipe_reg[i] <= pipe_reg[i-1];
         tx_de_reg   <= pipe_last.de;
         tx_hs_reg   <= pipe_last.hs ? HS_POL : ~HS_POL;
         tx_vs_reg   <= pipe_last.vs ? VS_POL : ~VS_POL;
         tx_fs_reg   <= pipe_last.fs;
         tx_ls_reg   <= pipe_last.ls;
         tx_pat_reg  <= pipe_last.pat;
         tx_rgb_reg  <= pipe_last.de ? pat_rgb : '0;
      end
   end

   // External pixels arrive in the same clock as their TX_DE, so source 0 bypasses the colour register.
   assign pix_rgb = {PIX_BLU, PIX_GRN, PIX_RED};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_chan
         assign tx_rgb[gi] = !tx_de_reg ? 8'h00 :
                             (tx_pat_reg == 2'd0) ? pix_rgb[gi] : tx_rgb_reg[gi];
      end
   endgenerate

   assign PIX_REQ     = pix_req_reg;
   assign PIX_X       = pix_x_reg;
   assign PIX_Y       = pix_y_reg;
   assign TX_RED      = tx_rgb[0];
   assign TX_GRN      = tx_rgb[1];
   assign TX_BLU      = tx_rgb[2];
   assign TX_HS       = tx_hs_reg;
   assign TX_VS       = tx_vs_reg;
   assign TX_DE       = tx_de_reg;
   assign FRAME_START = tx_fs_reg;
   assign LINE_START  = tx_ls_reg;

endmodule

// File: tb/tb_dvi_video_timing.sv
// Directed bench for dvi_video_timing on a tiny 14x7 raster (8x4 active).
module tb_dvi_video_timing;

   localparam int HT = 14;
   localparam int VT = 7;
   localparam int FT = HT * VT;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [1:0]  pat;
   logic [7:0]  pix_red, pix_grn, pix_blu;
   logic        pix_req;
   logic [11:0] pix_x, pix_y;
   logic [7:0]  tx_red, tx_grn, tx_blu;
   logic        tx_hs, tx_vs, tx_de, frame_start, line_start;

   int vectors = 0;
   int errors  = 0;

   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   always #5 clk = ~clk;

   dvi_video_timing #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut (
      .CLK(clk), .RESET(rst), .ENABLE(en), .PAT_SEL(pat),
      .PIX_RED(pix_red), .PIX_GRN(pix_grn), .PIX_BLU(pix_blu),
      .PIX_REQ(pix_req), .PIX_X(pix_x), .PIX_Y(pix_y),
      .TX_RED(tx_red), .TX_GRN(tx_grn), .TX_BLU(tx_blu),
      .TX_HS(tx_hs), .TX_VS(tx_vs), .TX_DE(tx_de),
      .FRAME_START(frame_start), .LINE_START(line_start)
   );

   // External pixel source: two register stages after PIX_REQ, value {x, y, x^y}.
   logic        m1_v, m2_v;
   logic [11:0] m1_x, m1_y, m2_x, m2_y;
   always @(posedge clk) begin
      m1_v <= pix_req; m1_x <= pix_x; m1_y <= pix_y;
      m2_v <= m1_v;    m2_x <= m1_x;  m2_y <= m1_y;
   end
   assign pix_red = m2_v ? m2_x[7:0] : 8'h00;
   assign pix_grn = m2_v ? m2_y[7:0] : 8'h00;
   assign pix_blu = m2_v ? (m2_x[7:0] ^ m2_y[7:0]) : 8'h00;

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_frame_start(output bit ok);
      int w;
      w = 0;
      while (frame_start !== 1'b1 && w < 300) begin
         tick();
         w++;
      end
      ok = (frame_start === 1'b1);
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b0; pat = 2'd0;
      repeat (3) tick();
      vectors++; if (pix_req !== 1'b0) begin errors++; $display("FAIL reset_pix_req got %0b want 0", pix_req); end
      vectors++; if ({pix_x, pix_y} !== 24'd0) begin errors++; $display("FAIL reset_pix_xy got %0d,%0d want 0,0", pix_x, pix_y); end
      vectors++; if ({tx_red, tx_grn, tx_blu} !== 24'd0) begin errors++; $display("FAIL reset_rgb got %06h want 000000", {tx_red, tx_grn, tx_blu}); end
      vectors++; if ({tx_de, tx_hs, tx_vs} !== 3'b011) begin errors++; $display("FAIL reset_de_hs_vs got %03b want 011", {tx_de, tx_hs, tx_vs}); end
      vectors++; if ({frame_start, line_start} !== 2'b00) begin errors++; $display("FAIL reset_fs_ls got %02b want 00", {frame_start, line_start}); end
      $display("test_reset done");
   endtask

   task automatic test_first_line;
      int n, h, v, q, hq, vq;
      logic e_req, e_de, e_hs, e_fs, e_ls;
      logic [11:0] e_x, e_y;
      rst = 1'b0; en = 1'b1; pat = 2'd0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         n = k - 1; h = n % HT; v = n / HT;
         e_req = (h < 8) && (v < 4);
         e_x = e_req ? 12'(h) : 12'd0;
         e_y = e_req ? 12'(v) : 12'd0;
         q = k - 3;
         if (q < 0) begin
            e_de = 1'b0; e_hs = 1'b1; e_fs = 1'b0; e_ls = 1'b0;
         end else begin
            hq = q % HT; vq = q / HT;
            e_de = (hq < 8) && (vq < 4);
            e_hs = !(hq == 10 || hq == 11);
            e_fs = (q == 0);
            e_ls = (hq == 0);
         end
         vectors++; if (pix_req !== e_req) begin errors++; $display("FAIL first_pix_req clk %0d got %0b want %0b", k, pix_req, e_req); end
         vectors++; if ({pix_x, pix_y} !== {e_x, e_y}) begin errors++; $display("FAIL first_pix_xy clk %0d got %0d,%0d want %0d,%0d", k, pix_x, pix_y, e_x, e_y); end
         vectors++; if (tx_de !== e_de) begin errors++; $display("FAIL first_de clk %0d got %0b want %0b", k, tx_de, e_de); end
         vectors++; if (tx_hs !== e_hs) begin errors++; $display("FAIL first_hs clk %0d got %0b want %0b", k, tx_hs, e_hs); end
         vectors++; if ({frame_start, line_start} !== {e_fs, e_ls}) begin errors++; $display("FAIL first_fs_ls clk %0d got %02b want %02b", k, {frame_start, line_start}, {e_fs, e_ls}); end
      end
      $display("test_first_line done");
   endtask

   // One whole frame with the given source; starts and ends on a FRAME_START clock.
   task automatic test_frame(input logic [1:0] sel);
      bit ok;
      int h, v, npix;
      logic e_de, e_hs, e_vs;
      logic [23:0] e_rgb;
      pat = sel;
      tick();
      wait_frame_start(ok);
      vectors++; if (!ok) begin errors++; $display("FAIL frame%0d_sync got no FRAME_START want one", sel); end
      npix = 0;
      for (int i = 0; i < FT; i++) begin
         h = i % HT; v = i / HT;
         e_de = (h < 8) && (v < 4);
         e_hs = !(h == 10 || h == 11);
         e_vs = (v != 5);
         case (sel)
            2'd0: e_rgb = {8'(h), 8'(v), 8'(h ^ v)};
            2'd1: e_rgb = bars[h % 8];
            2'd2: e_rgb = (h == 0 || v == 0) ? 24'hFFFFFF : 24'h000000;
            default: e_rgb = 24'h808080;
         endcase
         if (!e_de) e_rgb = 24'h000000;
         if (tx_de === 1'b1) npix++;
         vectors++; if (tx_de !== e_de) begin errors++; $display("FAIL frame%0d_de h%0d v%0d got %0b want %0b", sel, h, v, tx_de, e_de); end
         vectors++; if ({tx_red, tx_grn, tx_blu} !== e_rgb) begin errors++; $display("FAIL frame%0d_rgb h%0d v%0d got %06h want %06h", sel, h, v, {tx_red, tx_grn, tx_blu}, e_rgb); end
         vectors++; if ({tx_hs, tx_vs} !== {e_hs, e_vs}) begin errors++; $display("FAIL frame%0d_sync h%0d v%0d got %02b want %02b", sel, h, v, {tx_hs, tx_vs}, {e_hs, e_vs}); end
         vectors++; if ({frame_start, line_start} !== {(i == 0), (h == 0)}) begin errors++; $display("FAIL frame%0d_fs_ls h%0d v%0d got %02b want %0b%0b", sel, h, v, {frame_start, line_start}, (i == 0), (h == 0)); end
         tick();
      end
      vectors++; if (npix != 32) begin errors++; $display("FAIL frame%0d_pixels got %0d want 32", sel, npix); end
      vectors++; if (frame_start !== 1'b1) begin errors++; $display("FAIL frame%0d_period got fs=%0b at clk 98 want 1", sel, frame_start); end
      $display("test_frame sel=%0d done, %0d pixels", sel, npix);
   endtask

   task automatic test_pat_switch;
      logic [1:0] hist [8];
      logic [23:0] e_rgb;
      for (int i = 0; i < 8; i++) begin
         if (i >= 3) begin
            e_rgb = (hist[i-3] == 2'd3) ? 24'h808080 : bars[i];
            vectors++; if ({tx_red, tx_grn, tx_blu} !== e_rgb) begin errors++; $display("FAIL pat_switch_rgb x%0d got %06h want %06h", i, {tx_red, tx_grn, tx_blu}, e_rgb); end
         end
         hist[i] = (i % 2 == 1) ? 2'd3 : 2'd1;
         pat = hist[i];
         tick();
      end
      $display("test_pat_switch done");
   endtask

   task automatic test_enable_drop;
      bit ok;
      int h, v;
      logic e_de, e_hs, e_vs;
      pat = 2'd0;
      wait_frame_start(ok);
      vectors++; if (!ok) begin errors++; $display("FAIL drop_sync got no FRAME_START want one"); end
      for (int i = 0; i < FT; i++) begin
         if (i == 14) en = 1'b0;
         h = i % HT; v = i / HT;
         e_de = (h < 8) && (v < 4);
         e_hs = !(h == 10 || h == 11);
         e_vs = (v != 5);
         vectors++; if ({tx_de, tx_hs, tx_vs} !== {e_de, e_hs, e_vs}) begin errors++; $display("FAIL drop_frame h%0d v%0d got %03b want %0b%0b%0b", h, v, {tx_de, tx_hs, tx_vs}, e_de, e_hs, e_vs); end
         tick();
      end
      for (int i = 0; i < 8; i++) begin
         vectors++; if ({pix_req, tx_de, tx_hs, tx_vs, frame_start, line_start} !== 6'b001100) begin errors++; $display("FAIL drop_idle clk %0d got %06b want 001100", i, {pix_req, tx_de, tx_hs, tx_vs, frame_start, line_start}); end
         tick();
      end
      en = 1'b1;
      tick();
      vectors++; if (frame_start !== 1'b0) begin errors++; $display("FAIL restart_fs1 got %0b want 0", frame_start); end
      tick();
      vectors++; if (frame_start !== 1'b0) begin errors++; $display("FAIL restart_fs2 got %0b want 0", frame_start); end
      tick();
      vectors++; if ({frame_start, tx_de} !== 2'b11) begin errors++; $display("FAIL restart_fs3 got fs/de %02b want 11", {frame_start, tx_de}); end
      $display("test_enable_drop done");
   endtask

   task automatic test_reset_midframe;
      repeat (29) tick();
      vectors++; if ({pix_req, pix_x, pix_y} !== {1'b1, 12'd3, 12'd2}) begin errors++; $display("FAIL midrst_pos got req%0b %0d,%0d want req1 3,2", pix_req, pix_x, pix_y); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++; if ({pix_req, pix_x, pix_y} !== 25'd0) begin errors++; $display("FAIL midrst_pix got req%0b %0d,%0d want req0 0,0", pix_req, pix_x, pix_y); end
      vectors++; if ({tx_red, tx_grn, tx_blu} !== 24'd0) begin errors++; $display("FAIL midrst_rgb got %06h want 000000", {tx_red, tx_grn, tx_blu}); end
      vectors++; if ({tx_de, tx_hs, tx_vs, frame_start, line_start} !== 5'b01100) begin errors++; $display("FAIL midrst_ctl got %05b want 01100", {tx_de, tx_hs, tx_vs, frame_start, line_start}); end
      tick();
      vectors++; if ({pix_req, pix_x, pix_y, tx_de} !== {1'b1, 12'd0, 12'd0, 1'b0}) begin errors++; $display("FAIL midrst_r1 got req%0b %0d,%0d de%0b want req1 0,0 de0", pix_req, pix_x, pix_y, tx_de); end
      tick();
      vectors++; if ({pix_x, tx_de} !== {12'd1, 1'b0}) begin errors++; $display("FAIL midrst_r2 got x%0d de%0b want x1 de0", pix_x, tx_de); end
      tick();
      vectors++; if ({frame_start, line_start, tx_de} !== 3'b111) begin errors++; $display("FAIL midrst_r3 got fs/ls/de %03b want 111", {frame_start, line_start, tx_de}); end
      $display("test_reset_midframe done");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_first_line();
      test_frame(2'd0);
      test_frame(2'd1);
      test_frame(2'd2);
      test_frame(2'd3);
      test_pat_switch();
      test_enable_drop();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
